led_pattern_sequencer: RTL and testbench

Register-configured LED pattern sequencer. Plays a programmable table of LED patterns, each held for a programmable number of clock cycles, either once or looping. Sits between the AXI register slave (control and status fields) and the board LED outputs, replacing direct per-LED register drive.

---
 rtl/led_seq_pkg.sv | 19 +
 rtl/led_seq_table.sv | 33 +++
 rtl/led_pattern_sequencer.sv | 154 +++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types for the LED pattern sequencer.
// State encoding, step record layout and status counter width.
package led_seq_pkg;

  localparam int LOOP_CNT_W_C = 16;
  localparam int STEP_LED_W_C = 4;
  localparam int STEP_DUR_W_C = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } led_seq_state_e;

  typedef struct packed {
    logic [STEP_LED_W_C-1:0] pattern;
    logic [STEP_DUR_W_C-1:0] duration;
  } led_step_t;

endpackage

// File: rtl/led_seq_table.sv
// Step table: one write port, pattern and duration read combinationally.
// Contents are deliberately not reset; software programs them before start.
module led_seq_table #(
  parameter int NR_OF_LEDS_C      = 4,
  parameter int NR_OF_STEPS_C     = 8,
  parameter int DURATION_WIDTH_C  = 32,
  parameter int STEP_ADDR_WIDTH_C = $clog2(NR_OF_STEPS_C)
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [STEP_ADDR_WIDTH_C-1:0] wr_addr,
  input  logic [NR_OF_LEDS_C-1:0]      wr_pattern,
  input  logic [DURATION_WIDTH_C-1:0]  wr_duration,
  input  logic [STEP_ADDR_WIDTH_C-1:0] rd_dur_addr,
  output logic [DURATION_WIDTH_C-1:0]  rd_duration,
  input  logic [STEP_ADDR_WIDTH_C-1:0] rd_pat_addr,
  output logic [NR_OF_LEDS_C-1:0]      rd_pattern
);

  logic [NR_OF_LEDS_C-1:0]     pat_q [NR_OF_STEPS_C];
  logic [DURATION_WIDTH_C-1:0] dur_q [NR_OF_STEPS_C];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pat_q[wr_addr] <= wr_pattern;
      dur_q[wr_addr] <= wr_duration;
    end
  end

  assign rd_duration = dur_q[rd_dur_addr];
  assign rd_pattern  = pat_q[rd_pat_addr];

endmodule

// File: rtl/led_pattern_sequencer.sv
// Plays a programmable table of LED patterns, once or looping.
// Duration is read live from the table; the next pattern is preloaded at step end.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int NR_OF_LEDS_C      = 4,
  parameter int NR_OF_STEPS_C     = 8,
  parameter int DURATION_WIDTH_C  = 32,
  parameter int STEP_ADDR_WIDTH_C = $clog2(NR_OF_STEPS_C)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cr_start,
  input  logic                         cr_stop,
  input  logic                         cr_loop,
  input  logic [STEP_ADDR_WIDTH_C-1:0] cr_last_step,
  input  logic [NR_OF_LEDS_C-1:0]      cr_idle_pattern,
  input  logic                         cr_tbl_wr_en,
  input  logic [STEP_ADDR_WIDTH_C-1:0] cr_tbl_wr_addr,
  input  logic [NR_OF_LEDS_C-1:0]      cr_tbl_wr_pattern,
  input  logic [DURATION_WIDTH_C-1:0]  cr_tbl_wr_duration,
  output logic [NR_OF_LEDS_C-1:0]      led_pattern,
  output logic                         sr_busy,
  output logic [STEP_ADDR_WIDTH_C-1:0] sr_step,
  output logic [LOOP_CNT_W_C-1:0]      sr_loop_count,
  output logic                         irq_done
);

  led_seq_state_e               state_q, state_d;
  logic [STEP_ADDR_WIDTH_C-1:0] step_q, step_d;
  logic [DURATION_WIDTH_C-1:0]  cnt_q, cnt_d;
  logic [NR_OF_LEDS_C-1:0]      led_q, led_d;
  logic [LOOP_CNT_W_C-1:0]      loop_q, loop_d;
  logic                         irq_q, irq_d;

  logic [DURATION_WIDTH_C-1:0]  cur_dur;
  logic [DURATION_WIDTH_C-1:0]  dur_lim;
  logic [NR_OF_LEDS_C-1:0]      nxt_pat;
  logic [STEP_ADDR_WIDTH_C-1:0] nxt_addr;
  logic [LOOP_CNT_W_C-1:0]      loop_inc;
  logic                         is_last;
  logic                         step_end;
  logic                         is_idle;

  led_seq_table #(
    .NR_OF_LEDS_C      (NR_OF_LEDS_C),
    .NR_OF_STEPS_C     (NR_OF_STEPS_C),
    .DURATION_WIDTH_C  (DURATION_WIDTH_C),
    .STEP_ADDR_WIDTH_C (STEP_ADDR_WIDTH_C)
  ) u_table (
    .clk         (clk),
    .wr_en       (cr_tbl_wr_en),
    .wr_addr     (cr_tbl_wr_addr),
    .wr_pattern  (cr_tbl_wr_pattern),
    .wr_duration (cr_tbl_wr_duration),
    .rd_dur_addr (step_q),
    .rd_duration (cur_dur),
    .rd_pat_addr (nxt_addr),
    .rd_pattern  (nxt_pat)
  );

  assign is_idle = (state_q == ST_IDLE);
  // >= so that lowering cr_last_step mid-pass still terminates the pass
  assign is_last = (step_q >= cr_last_step);

  // Duration 0 behaves as 1; >= ends a step early if shortened live
  assign dur_lim = (cur_dur == '0) ? '0
                 : cur_dur - DURATION_WIDTH_C'(1);
  assign step_end = (cnt_q >= dur_lim);

  assign nxt_addr = (is_idle || cr_start || is_last) ? '0
                  : step_q + STEP_ADDR_WIDTH_C'(1);

  assign loop_inc = (loop_q == '1) ? loop_q
                  : loop_q + LOOP_CNT_W_C'(1);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    loop_d  = loop_q;
    irq_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        led_d  = cr_idle_pattern;
        step_d = '0;
        cnt_d  = '0;
        if (cr_start && !cr_stop) begin
          state_d = ST_RUN;
          led_d   = nxt_pat;
          loop_d  = '0;
        end
      end
      ST_RUN: begin
        if (cr_stop) begin
          state_d = ST_IDLE;
          led_d   = cr_idle_pattern;
          step_d  = '0;
          cnt_d   = '0;
        end else if (cr_start) begin
          step_d = '0;
          cnt_d  = '0;
          led_d  = nxt_pat;
          loop_d = '0;
        end else if (!step_end) begin
          cnt_d = cnt_q + DURATION_WIDTH_C'(1);
        end else if (!is_last) begin
          step_d = nxt_addr;
          cnt_d  = '0;
          led_d  = nxt_pat;
        end else if (cr_loop) begin
          step_d = '0;
          cnt_d  = '0;
          led_d  = nxt_pat;
          loop_d = loop_inc;
        end else begin
          state_d = ST_IDLE;
          step_d  = '0;
          cnt_d   = '0;
          led_d   = cr_idle_pattern;
          loop_d  = loop_inc;
          irq_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      led_q   <= '0;
      loop_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      loop_q  <= loop_d;
      irq_q   <= irq_d;
    end
  end

  assign led_pattern   = led_q;
  assign sr_busy       = (state_q == ST_RUN);
  assign sr_step       = step_q;
  assign sr_loop_count = loop_q;
  assign irq_done      = irq_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer.
// Expected LED streams are expanded from the table into per-cycle queues.
module tb_led_pattern_sequencer;
  import led_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cr_start, cr_stop, cr_loop;
  logic [2:0]  cr_last_step;
  logic [3:0]  cr_idle_pattern;
  logic        cr_tbl_wr_en;
  logic [2:0]  cr_tbl_wr_addr;
  logic [3:0]  cr_tbl_wr_pattern;
  logic [31:0] cr_tbl_wr_duration;
  logic [3:0]  led_pattern;
  logic        sr_busy;
  logic [2:0]  sr_step;
  logic [15:0] sr_loop_count;
  logic        irq_done;

  led_pattern_sequencer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cr_start           (cr_start),
    .cr_stop            (cr_stop),
    .cr_loop            (cr_loop),
    .cr_last_step       (cr_last_step),
    .cr_idle_pattern    (cr_idle_pattern),
    .cr_tbl_wr_en       (cr_tbl_wr_en),
    .cr_tbl_wr_addr     (cr_tbl_wr_addr),
    .cr_tbl_wr_pattern  (cr_tbl_wr_pattern),
    .cr_tbl_wr_duration (cr_tbl_wr_duration),
    .led_pattern        (led_pattern),
    .sr_busy            (sr_busy),
    .sr_step            (sr_step),
    .sr_loop_count      (sr_loop_count),
    .irq_done           (irq_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  led_step_t m_tbl [8];
  int exp_pat [$];
  int exp_step [$];

  typedef struct {
    logic [3:0] idle;
    logic [3:0] exp_led;
    logic       exp_busy;
  } idle_vec_t;

  idle_vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input int a, input int p, input int d);
    cr_tbl_wr_en       = 1'b1;
    cr_tbl_wr_addr     = 3'(a);
    cr_tbl_wr_pattern  = 4'(p);
    cr_tbl_wr_duration = 32'(d);
    tick();
    cr_tbl_wr_en = 1'b0;
    m_tbl[a].pattern  = 4'(p);
    m_tbl[a].duration = 32'(d);
  endtask

  task automatic pulse_start();
    cr_start = 1'b1;
    tick();
    cr_start = 1'b0;
  endtask

  // One pass: each step shows its pattern max(duration,1) cycles
  task automatic build(input int last);
    exp_pat.delete();
    exp_step.delete();
    for (int s = 0; s <= last; s++) begin
      int n;
      n = (m_tbl[s].duration == 0) ? 1 : int'(m_tbl[s].duration);
      for (int r = 0; r < n; r++) begin
        exp_pat.push_back(int'(m_tbl[s].pattern));
        exp_step.push_back(s);
      end
    end
  endtask

  task automatic check_once();
    for (int k = 0; k < exp_pat.size(); k++) begin
      chk("once_led", int'(led_pattern), exp_pat[k]);
      chk("once_step", int'(sr_step), exp_step[k]);
      chk("once_busy", int'(sr_busy), 1);
      chk("once_irq", int'(irq_done), 0);
      chk("once_loopcnt", int'(sr_loop_count), 0);
      tick();
    end
    chk("done_irq", int'(irq_done), 1);
    chk("done_busy", int'(sr_busy), 0);
    chk("done_led", int'(led_pattern), int'(cr_idle_pattern));
    chk("done_loopcnt", int'(sr_loop_count), 1);
    tick();
    chk("done_irq_clear", int'(irq_done), 0);
    chk("done_loopcnt_hold", int'(sr_loop_count), 1);
  endtask

  task automatic check_loop(input int ncyc);
    int len;
    len = exp_pat.size();
    for (int k = 0; k <= ncyc; k++) begin
      int lc;
      lc = k / len;
      if (lc > 65535) lc = 65535;
      chk("loop_led", int'(led_pattern), exp_pat[k % len]);
      chk("loop_step", int'(sr_step), exp_step[k % len]);
      chk("loop_cnt", int'(sr_loop_count), lc);
      chk("loop_busy", int'(sr_busy), 1);
      chk("loop_irq", int'(irq_done), 0);
      if (k < ncyc) tick();
    end
  endtask

  task automatic stop_check();
    cr_stop = 1'b1;
    tick();
    cr_stop = 1'b0;
    chk("stop_busy", int'(sr_busy), 0);
    chk("stop_led", int'(led_pattern), int'(cr_idle_pattern));
    chk("stop_step", int'(sr_step), 0);
    chk("stop_irq", int'(irq_done), 0);
  endtask

  initial begin
    rst_n              = 1'b0;
    cr_start           = 1'b0;
    cr_stop            = 1'b0;
    cr_loop            = 1'b0;
    cr_last_step       = 3'd0;
    cr_idle_pattern    = 4'd0;
    cr_tbl_wr_en       = 1'b0;
    cr_tbl_wr_addr     = 3'd0;
    cr_tbl_wr_pattern  = 4'd0;
    cr_tbl_wr_duration = 32'd0;
    for (int i = 0; i < 8; i++) m_tbl[i] = '0;

    repeat (2) tick();
    chk("rst_led", int'(led_pattern), 0);
    chk("rst_busy", int'(sr_busy), 0);
    chk("rst_step", int'(sr_step), 0);
    chk("rst_loopcnt", int'(sr_loop_count), 0);
    chk("rst_irq", int'(irq_done), 0);
    rst_n = 1'b1;
    tick();

    vecs[0] = '{4'b1010, 4'b1010, 1'b0};
    vecs[1] = '{4'b0101, 4'b0101, 1'b0};
    vecs[2] = '{4'b1111, 4'b1111, 1'b0};
    vecs[3] = '{4'b0000, 4'b0000, 1'b0};
    for (int i = 0; i < 4; i++) begin
      cr_idle_pattern = vecs[i].idle;
      tick();
      chk("idle_led", int'(led_pattern), int'(vecs[i].exp_led));
      chk("idle_busy", int'(sr_busy), int'(vecs[i].exp_busy));
    end

    cr_idle_pattern = 4'b1010;
    wr(0, 4'b0001, 3);
    wr(1, 4'b0010, 5);
    wr(2, 4'b0100, 1);
    cr_last_step = 3'd2;
    cr_loop      = 1'b0;
    build(2);
    pulse_start();
    check_once();

    cr_loop = 1'b1;
    pulse_start();
    check_loop(27);
    chk("loop27_cnt", int'(sr_loop_count), 3);
    chk("loop27_step", int'(sr_step), 0);

    cr_start = 1'b1;
    cr_stop  = 1'b1;
    tick();
    cr_start = 1'b0;
    cr_stop  = 1'b0;
    chk("ss_busy", int'(sr_busy), 0);
    chk("ss_led", int'(led_pattern), 4'b1010);
    chk("ss_irq", int'(irq_done), 0);
    tick();
    chk("ss_irq_after", int'(irq_done), 0);
    chk("ss_busy_after", int'(sr_busy), 0);

    cr_loop = 1'b0;
    pulse_start();
    repeat (4) tick();
    chk("mid_step1", int'(sr_step), 1);
    pulse_start();
    check_once();

    wr(1, 4'b0110, 0);
    build(2);
    pulse_start();
    check_once();

    for (int it = 0; it < 20; it++) begin
      int last;
      last = int'($urandom_range(0, 7));
      for (int a = 0; a < 8; a++)
        wr(a, int'($urandom_range(0, 15)), int'($urandom_range(0, 4)));
      cr_last_step    = 3'(last);
      cr_loop         = 1'($urandom_range(0, 1));
      cr_idle_pattern = 4'($urandom_range(0, 15));
      build(last);
      pulse_start();
      if (!cr_loop) begin
        check_once();
      end else begin
        check_loop(int'($urandom_range(5, 40)));
        stop_check();
      end
    end

    wr(0, 4'b1001, 1);
    cr_last_step = 3'd0;
    cr_loop      = 1'b1;
    pulse_start();
    repeat (65535) tick();
    chk("sat_cnt", int'(sr_loop_count), 16'hFFFF);
    repeat (3) tick();
    chk("sat_cnt_hold", int'(sr_loop_count), 16'hFFFF);
    chk("sat_busy", int'(sr_busy), 1);

    wr(0, 4'b1100, 4);
    cr_idle_pattern = 4'b0011;
    pulse_start();
    repeat (2) tick();
    rst_n = 1'b0;
    #2;
    chk("arst_led", int'(led_pattern), 0);
    chk("arst_busy", int'(sr_busy), 0);
    chk("arst_step", int'(sr_step), 0);
    chk("arst_loopcnt", int'(sr_loop_count), 0);
    chk("arst_irq", int'(irq_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", int'(sr_busy), 0);
    chk("post_rst_led", int'(led_pattern), 4'b0011);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
